service_2_countdown: RTL and testbench

- Countdown engine directly downstream of the MM:SS time-set service.
- On the time-set block's one-cycle finish pulse, it captures the 16-bit BCD time, then counts down once per second under start/pause control.
- Drives the remaining time to the 7-segment display path and raises done/alarm at 00:00.
- Single clock domain; all inputs already debounced, single-cycle pulses.

---
 rtl/service_pkg.sv | 17 +
 rtl/bcd_time_dec.sv | 56 +++++
 rtl/service_2_countdown.sv | 98 +++++++++
 tb/tb_service_2_countdown.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/service_pkg.sv
// Shared definitions for the MM:SS time services: countdown states and BCD field layout.
package service_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PAUSED = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Bit offsets of each BCD nibble within the 16-bit {min_t, min_o, sec_t, sec_o} word
    localparam int unsigned MIN_T_LSB = 12;
    localparam int unsigned MIN_O_LSB = 8;
    localparam int unsigned SEC_T_LSB = 4;
    localparam int unsigned SEC_O_LSB = 0;

endpackage

// File: rtl/bcd_time_dec.sv
// Combinational one-second decrement of a BCD MM:SS word, plus a flag for a 00:00 result.
module bcd_time_dec
    import service_pkg::*;
(
    input  logic [15:0] time_i,
    output logic [15:0] time_o,
    output logic        zero_o
);

    logic [3:0] so, st, mo, mt;
    logic       b_so, b_st, b_mo;

    always_comb begin
        so     = time_i[SEC_O_LSB +: 4];
        st     = time_i[SEC_T_LSB +: 4];
        mo     = time_i[MIN_O_LSB +: 4];
        mt     = time_i[MIN_T_LSB +: 4];
        time_o = time_i;
        b_so   = 1'b0;
        b_st   = 1'b0;
        b_mo   = 1'b0;

        if (so == 4'd0) begin
            time_o[SEC_O_LSB +: 4] = 4'd9;
            b_so                   = 1'b1;
        end else begin
            time_o[SEC_O_LSB +: 4] = so - 4'd1;
        end

        // Seconds-tens above 5 just count down until the first borrow wraps them to 5
        if (b_so) begin
            if (st == 4'd0) begin
                time_o[SEC_T_LSB +: 4] = 4'd5;
                b_st                   = 1'b1;
            end else begin
                time_o[SEC_T_LSB +: 4] = st - 4'd1;
            end
        end

        if (b_st) begin
            if (mo == 4'd0) begin
                time_o[MIN_O_LSB +: 4] = 4'd9;
                b_mo                   = 1'b1;
            end else begin
                time_o[MIN_O_LSB +: 4] = mo - 4'd1;
            end
        end

        if (b_mo) begin
            time_o[MIN_T_LSB +: 4] = mt - 4'd1;
        end

        zero_o = (time_o == '0);
    end

endmodule

// File: rtl/service_2_countdown.sv
// MM:SS countdown engine: loads from the time-set block, counts down once per second, flags 00:00.
module service_2_countdown
    import service_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000,
    parameter int CNT_W    = 27
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] time_in,
    input  logic        start_stop,
    output logic [15:0] num,
    output logic        running,
    output logic        done,
    output logic        alarm
);

    state_e             state_q;
    logic [15:0]        num_q;
    logic [CNT_W-1:0]   presc_q;
    logic               running_q;
    logic               done_q;
    logic               alarm_q;

    logic [15:0]        num_dec;
    logic               dec_zero;
    logic               tick;

    bcd_time_dec u_dec (
        .time_i (num_q),
        .time_o (num_dec),
        .zero_o (dec_zero)
    );

    assign tick = (state_q == ST_RUN) && (presc_q == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            num_q     <= '0;
            presc_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load) begin
                num_q     <= time_in;
                presc_q   <= '0;
                alarm_q   <= 1'b0;
                running_q <= 1'b0;
                state_q   <= (time_in != '0) ? ST_PAUSED : ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: ;
                    ST_PAUSED: begin
                        if (start_stop) begin
                            state_q   <= ST_RUN;
                            running_q <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        // Reaching 00:00 wins over a pause request arriving on the same tick
                        if (tick) begin
                            presc_q <= '0;
                            num_q   <= num_dec;
                        end else begin
                            presc_q <= presc_q + 1'b1;
                        end
                        if (tick && dec_zero) begin
                            state_q   <= ST_DONE;
                            running_q <= 1'b0;
                            done_q    <= 1'b1;
                            alarm_q   <= 1'b1;
                        end else if (start_stop) begin
                            state_q   <= ST_PAUSED;
                            running_q <= 1'b0;
                        end
                    end
                    ST_DONE: begin
                        if (start_stop) begin
                            state_q <= ST_IDLE;
                            alarm_q <= 1'b0;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign num     = num_q;
    assign running = running_q;
    assign done    = done_q;
    assign alarm   = alarm_q;

endmodule

// File: tb/tb_service_2_countdown.sv
// Bench for service_2_countdown: seconds-level reference model plus directed literal checks.
module tb_service_2_countdown;

    localparam int TICK_DIV = 4;

    localparam int M_IDLE   = 0;
    localparam int M_PAUSED = 1;
    localparam int M_RUN    = 2;
    localparam int M_DONE   = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] time_in = '0;
    logic        start_stop = 1'b0;
    logic [15:0] num;
    logic        running;
    logic        done;
    logic        alarm;

    int checks = 0;
    int errors = 0;

    // Reference model: minutes and seconds as plain integers
    int ms    = M_IDLE;
    int mmin  = 0;
    int msec  = 0;
    int mcyc  = 0;
    bit mdone = 1'b0;
    bit malarm = 1'b0;

    service_2_countdown #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .time_in    (time_in),
        .start_stop (start_stop),
        .num        (num),
        .running    (running),
        .done       (done),
        .alarm      (alarm)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int m, input int s);
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ms = M_IDLE; mmin = 0; msec = 0; mcyc = 0; mdone = 1'b0; malarm = 1'b0;
        end else begin
            mdone = 1'b0;
            if (load) begin
                mmin   = int'(time_in[15:12]) * 10 + int'(time_in[11:8]);
                msec   = int'(time_in[7:4]) * 10 + int'(time_in[3:0]);
                mcyc   = 0;
                malarm = 1'b0;
                ms     = (mmin != 0 || msec != 0) ? M_PAUSED : M_IDLE;
            end else begin
                case (ms)
                    M_PAUSED: if (start_stop) ms = M_RUN;
                    M_RUN: begin
                        mcyc++;
                        if (mcyc == TICK_DIV) begin
                            mcyc = 0;
                            if (msec > 0) msec--;
                            else begin mmin--; msec = 59; end
                            if (mmin == 0 && msec == 0) begin
                                ms = M_DONE; mdone = 1'b1; malarm = 1'b1;
                            end
                        end
                        if (start_stop && ms == M_RUN) ms = M_PAUSED;
                    end
                    M_DONE: if (start_stop) begin ms = M_IDLE; malarm = 1'b0; end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("model_num", num, to_bcd(mmin, msec));
            check("model_running", running, 16'(ms == M_RUN));
            check("model_done", done, 16'(mdone));
            check("model_alarm", alarm, 16'(malarm));
        end
    end

    task automatic do_load(input logic [15:0] t, input logic ss);
        @(negedge clk);
        load = 1'b1; time_in = t; start_stop = ss;
        @(negedge clk);
        load = 1'b0; start_stop = 1'b0;
    endtask

    task automatic pulse_ss();
        @(negedge clk);
        start_stop = 1'b1;
        @(negedge clk);
        start_stop = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_num", num, 16'h0000);
        check("reset_running", running, 16'h0);
        check("reset_alarm", alarm, 16'h0);
        check("reset_done", done, 16'h0);
        reset = 1'b0;

        // Load and run from 00:03
        do_load(16'h0003, 1'b0);
        check("load3_num", num, 16'h0003);
        check("load3_running", running, 16'h0);
        pulse_ss();
        check("run3_running", running, 16'h1);
        repeat (3) @(negedge clk);
        check("run3_hold", num, 16'h0003);
        @(negedge clk);
        check("run3_t4", num, 16'h0002);
        repeat (4) @(negedge clk);
        check("run3_t8", num, 16'h0001);
        repeat (4) @(negedge clk);
        check("run3_t12", num, 16'h0000);
        check("run3_done", done, 16'h1);
        check("run3_alarm", alarm, 16'h1);
        check("run3_stop", running, 16'h0);
        @(negedge clk);
        check("run3_done_once", done, 16'h0);
        check("run3_alarm_hold", alarm, 16'h1);

        // Alarm acknowledge
        pulse_ss();
        check("ack_alarm", alarm, 16'h0);
        check("ack_running", running, 16'h0);

        // Minute borrow
        do_load(16'h0100, 1'b0);
        pulse_ss();
        repeat (4) @(negedge clk);
        check("borrow_0059", num, 16'h0059);
        repeat (236) @(negedge clk);
        check("borrow_zero", num, 16'h0000);
        check("borrow_done", done, 16'h1);

        // Load in DONE clears alarm and enters PAUSED
        do_load(16'h0025, 1'b0);
        check("reload_alarm", alarm, 16'h0);
        check("reload_num", num, 16'h0025);
        check("reload_running", running, 16'h0);

        // Pause 2 cycles into a second, then resume
        pulse_ss();
        @(negedge clk);
        start_stop = 1'b1;
        @(negedge clk);
        start_stop = 1'b0;
        repeat (10) @(negedge clk);
        check("pause_num", num, 16'h0025);
        check("pause_running", running, 16'h0);
        pulse_ss();
        @(negedge clk);
        check("resume_hold", num, 16'h0025);
        @(negedge clk);
        check("resume_dec", num, 16'h0024);

        // Zero load with start_stop in the same cycle
        do_load(16'h0000, 1'b1);
        check("zload_num", num, 16'h0000);
        check("zload_running", running, 16'h0);
        pulse_ss();
        @(negedge clk);
        check("zload_ignore", running, 16'h0);

        // Out-of-range seconds-tens
        do_load(16'h0090, 1'b0);
        pulse_ss();
        repeat (4 * 31) @(negedge clk);
        check("oor_0059", num, 16'h0059);

        // Async reset mid-RUN
        do_load(16'h0030, 1'b0);
        pulse_ss();
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("areset_num", num, 16'h0000);
        check("areset_running", running, 16'h0);
        check("areset_alarm", alarm, 16'h0);
        check("areset_done", done, 16'h0);
        @(negedge clk);
        #1 reset = 1'b0;
        repeat (8) @(negedge clk);
        check("areset_quiet", done, 16'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            load       = ($urandom_range(0, 39) == 0);
            start_stop = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0)
                time_in = 16'h0000;
            else
                time_in = {4'd0, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 9)),
                           4'($urandom_range(0, 9))};
        end
        @(negedge clk);
        load = 1'b0; start_stop = 1'b0;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
